imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time programmer for the instruction memory.
- Receives a byte stream from a serial receiver, assembles little-endian 32-bit words and drives the imem write port (write, addr_in, data).
- Holds the core in reset while a load is in progress and releases it when the load completes.
- Sits between the RX byte source, the imem write port and the core reset input.

Parameters:
- DEPTH, 256, number of 32-bit words in imem; bounds the legal load length.
- TIMEOUT_CYC, 1000000, maximum clk cycles allowed between consecutive rx bytes during a load before aborting.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  one-cycle pulse that begins a load; ignored while busy.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe qualifying rx_data; there is no backpressure.
- imem_write  output  1  imem write enable, one-cycle pulse per word.
- imem_addr  output  32  imem byte address, always word-aligned.
- imem_data  output  32  assembled word.
- cpu_rst_n  output  1  core reset, active low; 0 holds the core.
- busy  output  1  high while in LEN or DATA.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky abort flag; cleared by rst_n or by the next accepted start.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=IDLE, imem_write=0, imem_addr=0, imem_data=0, cpu_rst_n=1, busy=0, done=0, error=0, byte index=0, word count=0, timeout counter=0.
- States:
  - IDLE: start=1 -> LEN. On that transition: cpu_rst_n<=0, error<=0, imem_addr<=0, byte index<=0, timeout counter<=0.
  - LEN: collects 2 bytes into the 16-bit word count N, first byte = N[7:0].
    - After the 2nd byte, N=0 -> FIN.
    - N>DEPTH -> ERR.
    - Otherwise -> DATA.
  - DATA: each rx_valid byte fills lane byte index (lane 0 = bits 7:0). The byte index wraps 3->0.
    - On the 4th byte (edge N0), the completed word is registered into imem_data.
    - imem_write=1 for exactly the cycle after N0, with imem_addr holding the current address.
    - imem_addr advances by 4 on the edge ending that write cycle.
    - A byte arriving in the write cycle is captured normally, so no byte is lost.
    - After the write of word N-1 -> FIN.
  - FIN: single cycle. done=1, cpu_rst_n<=1 at the end of the cycle, then -> IDLE.
  - ERR: single cycle. error<=1, -> IDLE. cpu_rst_n stays 0 until the next successful load or rst_n.
- Timeout:
  - In LEN and DATA the counter increments every cycle and clears on rx_valid.
  - Reaching TIMEOUT_CYC -> ERR.
  - Any partially assembled word is discarded and never written.
- rx_valid in IDLE, FIN or ERR is ignored.
- start during LEN or DATA is ignored.
- start and rx_valid in the same IDLE cycle: start is taken and the byte is dropped.
- Address arithmetic:
  - imem_addr = 4*word_index.
  - Maximum written address = 4*(DEPTH-1).
  - Never wraps, because N<=DEPTH is enforced.
- busy = (state==LEN or DATA), derived combinationally from state.
- rst_n low mid-load aborts immediately to reset values. The core is released (cpu_rst_n=1) and no further writes occur.
- Latency:
  - start -> cpu_rst_n=0 at the next edge.
  - Last byte -> imem_write 1 cycle later -> done 1 cycle after that -> cpu_rst_n=1 on the following edge.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs at their reset values, cpu_rst_n=1, no imem_write.
- Normal load: start, then bytes 02 00, 13 01 10 00, 93 00 10 00 (N=2).
  - Required writes: addr 0x0 data 0x00100113 and addr 0x4 data 0x00100093, each imem_write one cycle wide, one cycle after the 4th byte.
  - Then done pulses once, cpu_rst_n returns to 1, busy=0.
- Zero length: start, then bytes 00 00 -> no imem_write; done pulses one cycle after the 2nd byte; cpu_rst_n=1.
- Oversize: start, then bytes 01 01 (N=257 > 256) -> error=1, no writes, cpu_rst_n stays 0. A following start clears error.
- Timeout: start, N=1, then 3 data bytes and silence for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=16) -> error=1, no imem_write.
- Mid-load reset and back-to-back bytes:
  - Bytes on consecutive cycles: the byte in the write cycle lands in lane 0 of the next word, and the data is correct.
  - rst_n=0 after word 0 -> imem_addr=0, busy=0, cpu_rst_n=1, and no further writes.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time imem programmer fed by an rx byte stream
module imem_loader #(
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_write,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]      DEPTH_L  = 17'(DEPTH);

  state_t           state;
  logic [1:0]       byte_idx;
  logic [15:0]      word_len;
  logic [15:0]      word_cnt;
  logic [23:0]      asm_lo;
  logic [CNT_W-1:0] tmo_cnt;
  logic [15:0]      len_next;

  assign busy     = (state == S_LEN) || (state == S_DATA);
  assign len_next = {rx_data, word_len[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      imem_write <= 1'b0;
      imem_addr  <= 32'd0;
      imem_data  <= 32'd0;
      cpu_rst_n  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_idx   <= 2'd0;
      word_len   <= 16'd0;
      word_cnt   <= 16'd0;
      asm_lo     <= 24'd0;
      tmo_cnt    <= '0;
    end else begin
      imem_write <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LEN;
            cpu_rst_n <= 1'b0;
            error     <= 1'b0;
            imem_addr <= 32'd0;
            byte_idx  <= 2'd0;
            word_cnt  <= 16'd0;
            tmo_cnt   <= '0;
          end
        end

        S_LEN: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            if (byte_idx == 2'd0) begin
              word_len[7:0] <= rx_data;
              byte_idx      <= 2'd1;
            end else begin
              word_len[15:8] <= rx_data;
              byte_idx       <= 2'd0;
              if (len_next == 16'd0) begin
                state <= S_FIN;
                done  <= 1'b1;
              end else if ({1'b0, len_next} > DEPTH_L) begin
                state <= S_ERR;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_DATA: begin
          // imem_write high means this is the write cycle of the previous word
          if (imem_write) begin
            imem_addr <= imem_addr + 32'd4;
            word_cnt  <= word_cnt + 16'd1;
          end
          if (imem_write && (word_cnt == word_len - 16'd1)) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else if (rx_valid) begin
            tmo_cnt  <= '0;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    asm_lo[7:0]   <= rx_data;
              2'd1:    asm_lo[15:8]  <= rx_data;
              2'd2:    asm_lo[23:16] <= rx_data;
              default: begin
                imem_data  <= {rx_data, asm_lo};
                imem_write <= 1'b1;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_FIN: begin
          cpu_rst_n <= 1'b1;
          state     <= S_IDLE;
        end

        S_ERR: begin
          error <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
